// File: rtl/rob_pkg.sv
// Shared types and default widths for the reorder-buffer retire logic.
//   commit_state_t : retire FSM states
//   rob_entry_t    : payload of the entry sitting at the ROB head
package rob_pkg;

  localparam int unsigned DEF_REG_ADDR = 5;
  localparam int unsigned DEF_DATA_W   = 64;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } commit_state_t;

  typedef struct packed {
    logic                    done;
    logic                    regWrite;
    logic [DEF_REG_ADDR-1:0] dest;
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_DATA_W-1:0]   addr;
    logic                    isStore;
    logic                    mispredict;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_unit.sv
// Retire-side controller for the reorder buffer.
// Retires completed head entries in program order, performs register writes,
// holds stores until memory accepts them and flushes on a mispredicted branch.
// Ports:
//   clk_i, reset_i (async, active low)
//   head_i / entry*_i      : ROB head index and head entry fields
//   storeReady_i           : memory accepts the pending store
//   updateHead_o, retireIdx_o, regWr*_o   : combinational retire/write strobes
//   store*_o               : registered store request (latched address/data)
//   needToRestore_o, redirect*_o          : registered flush and redirect
//   commitCount_o          : running count of retired instructions
module rob_commit_unit
  import rob_pkg::*;
#(
  parameter int unsigned ROBsize      = 16,
  parameter int unsigned addrSize     = $clog2(ROBsize),
  parameter int unsigned REG_ADDR     = DEF_REG_ADDR,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [addrSize-1:0] head_i,
  input  logic                entryValid_i,
  input  logic                entryDone_i,
  input  logic                entryRegWrite_i,
  input  logic [REG_ADDR-1:0] entryDest_i,
  input  logic [DATA_W-1:0]   entryData_i,
  input  logic [DATA_W-1:0]   entryAddr_i,
  input  logic                entryIsStore_i,
  input  logic                entryMispredict_i,
  input  logic                storeReady_i,
  output logic                updateHead_o,
  output logic [addrSize-1:0] retireIdx_o,
  output logic                regWrEn_o,
  output logic [REG_ADDR-1:0] regWrAddr_o,
  output logic [DATA_W-1:0]   regWrData_o,
  output logic                storeValid_o,
  output logic [DATA_W-1:0]   storeAddr_o,
  output logic [DATA_W-1:0]   storeData_o,
  output logic                needToRestore_o,
  output logic                redirectValid_o,
  output logic [DATA_W-1:0]   redirectPc_o,
  output logic [31:0]         commitCount_o
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned COUNT_W  = 32;

  commit_state_t        state_q, state_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [DATA_W-1:0]    st_addr_q, st_addr_d;
  logic [DATA_W-1:0]    st_data_q, st_data_d;
  logic                 st_misp_q, st_misp_d;
  logic                 store_valid_q, store_valid_d;
  logic                 need_restore_q, need_restore_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [DATA_W-1:0]    redirect_pc_q, redirect_pc_d;
  logic [COUNT_W-1:0]   commit_cnt_q, commit_cnt_d;

  logic ready;
  logic update_head;
  logic reg_wr_en;

  assign ready = entryValid_i & entryDone_i;

  // Next-state, retire strobes and registered-output next values.
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    st_addr_d        = st_addr_q;
    st_data_d        = st_data_q;
    st_misp_d        = st_misp_q;
    store_valid_d    = store_valid_q;
    need_restore_d   = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    update_head      = 1'b0;
    reg_wr_en        = 1'b0;

    unique case (state_q)
      RUN: begin
        if (ready) begin
          if (entryIsStore_i) begin
            // Capture the store; it retires once memory accepts it.
            st_addr_d     = entryAddr_i;
            st_data_d     = entryData_i;
            st_misp_d     = entryMispredict_i;
            store_valid_d = 1'b1;
            state_d       = STORE_WAIT;
          end else begin
            update_head = 1'b1;
            reg_wr_en   = entryRegWrite_i;
            if (entryMispredict_i) begin
              redirect_pc_d    = entryAddr_i;
              flush_cnt_d      = CNT_W'(FLUSH_CYCLES);
              need_restore_d   = 1'b1;
              redirect_valid_d = 1'b1;
              state_d          = FLUSH;
            end
          end
        end
      end

      STORE_WAIT: begin
        if (storeReady_i && store_valid_q) begin
          update_head   = 1'b1;
          store_valid_d = 1'b0;
          if (st_misp_q) begin
            redirect_pc_d    = st_addr_q;
            flush_cnt_d      = CNT_W'(FLUSH_CYCLES);
            need_restore_d   = 1'b1;
            redirect_valid_d = 1'b1;
            state_d          = FLUSH;
          end else begin
            state_d = RUN;
          end
        end
      end

      FLUSH: begin
        // Counter holds the remaining flush cycles including the current one.
        if (flush_cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
        end else begin
          flush_cnt_d    = flush_cnt_q - CNT_W'(1);
          need_restore_d = 1'b1;
        end
      end

      default: state_d = RUN;
    endcase

    commit_cnt_d = commit_cnt_q + COUNT_W'(update_head);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q          <= RUN;
      flush_cnt_q      <= '0;
      st_addr_q        <= '0;
      st_data_q        <= '0;
      st_misp_q        <= 1'b0;
      store_valid_q    <= 1'b0;
      need_restore_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      commit_cnt_q     <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      st_addr_q        <= st_addr_d;
      st_data_q        <= st_data_d;
      st_misp_q        <= st_misp_d;
      store_valid_q    <= store_valid_d;
      need_restore_q   <= need_restore_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      commit_cnt_q     <= commit_cnt_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign updateHead_o    = update_head & reset_i;
  assign retireIdx_o     = reset_i ? head_i : '0;
  assign regWrEn_o       = reg_wr_en & reset_i;
  assign regWrAddr_o     = regWrEn_o ? entryDest_i : '0;
  assign regWrData_o     = regWrEn_o ? entryData_i : '0;

  assign storeValid_o    = store_valid_q;
  assign storeAddr_o     = st_addr_q;
  assign storeData_o     = st_data_q;
  assign needToRestore_o = need_restore_q;
  assign redirectValid_o = redirect_valid_q;
  assign redirectPc_o    = redirect_pc_q;
  assign commitCount_o   = commit_cnt_q;

endmodule
